// File: rtl/ysyx_22050598_lsu_mc.sv
// ysyx_22050598_lsu_mc: multi-cycle load/store unit driving a req/ready + rvalid data bus.
// Define YSYX_22050598_LSU_MISALIGN_EN to split bus-word-crossing accesses into two beats.
module ysyx_22050598_lsu_mc #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ADDR_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_store,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_err,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_err
);
    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
`ifdef YSYX_22050598_LSU_MISALIGN_EN
        S_REQ1,
        S_WAIT1,
`endif
        S_RESP
    } state_t;

    state_t r_state, w_next;

    logic [OFFW-1:0]   r_off;
    logic [1:0]        r_size;
    logic              r_store;
    logic              r_unsigned;
    logic              r_err;
    logic              r_mem_valid;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [XLEN-1:0]   r_mem_wdata;
    logic [NB-1:0]     r_mem_wstrb;
    logic [XLEN-1:0]   r_rsp_rdata;

    logic [OFFW-1:0]   w_off;
    logic [3:0]        w_len;
    logic              w_bad;
    logic [NB-1:0]     w_bmask;
    logic [XLEN-1:0]   w_wmask;
    logic [XLEN-1:0]   w_wdata_m;
    logic [XLEN-1:0]   w_wdata_lo;
    logic [NB-1:0]     w_wstrb_lo;
    logic [ADDR_W-1:0] w_base;
    logic [OFFW+2:0]   w_sh;
    logic [OFFW+2:0]   r_sh;

    logic [3:0]        w_rlen;
    logic [XLEN-1:0]   w_rmask;
    logic [XLEN-1:0]   w_ld_sh;
    logic              w_sign;
    logic [XLEN-1:0]   w_ld_ext;

`ifdef YSYX_22050598_LSU_MISALIGN_EN
    logic              r_split;
    logic [XLEN-1:0]   r_wdata_hi;
    logic [NB-1:0]     r_wstrb_hi;
    logic [XLEN-1:0]   r_rdata0;
    logic              w_split;
    logic [XLEN-1:0]   w_wdata_hi;
    logic [NB-1:0]     w_wstrb_hi;
    logic [XLEN-1:0]   w_ld_lo;
    logic [XLEN-1:0]   w_ld_hi;
`endif

    // Request-side lane formation, evaluated on the accept cycle.
    always_comb begin
        w_off   = req_addr[OFFW-1:0];
        w_len   = 4'd1 << req_size;
        w_sh    = {w_off, 3'b000};
        w_base  = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        w_bmask = '0;
        w_wmask = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            w_bmask[i]       = (i < 32'(w_len));
            w_wmask[8*i +: 8] = {8{w_bmask[i]}};
        end
        w_wdata_m  = req_wdata & w_wmask;
        w_wdata_lo = w_wdata_m << w_sh;
        w_wstrb_lo = w_bmask << w_off;
`ifdef YSYX_22050598_LSU_MISALIGN_EN
        // A shift by the full width yields zero, so offset 0 leaves nothing for beat 1.
        w_wdata_hi = w_wdata_m >> (XLEN - 32'(w_sh));
        w_wstrb_hi = w_bmask >> (NB - 32'(w_off));
        w_split    = (32'(w_off) + 32'(w_len)) > NB;
        w_bad      = (XLEN == 32) && (req_size == 2'b11);
`else
        w_bad      = ((XLEN == 32) && (req_size == 2'b11)) ||
                     ((32'(w_off) & (32'(w_len) - 32'd1)) != 32'd0);
`endif
    end

    // Load alignment and extension from the registered request fields.
    always_comb begin
        r_sh    = {r_off, 3'b000};
        w_rlen  = 4'd1 << r_size;
        w_rmask = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            w_rmask[8*i +: 8] = {8{(i < 32'(w_rlen))}};
        end
`ifdef YSYX_22050598_LSU_MISALIGN_EN
        w_ld_lo = (r_state == S_WAIT1) ? r_rdata0  : mem_rdata;
        w_ld_hi = (r_state == S_WAIT1) ? mem_rdata : '0;
        w_ld_sh = (w_ld_lo >> r_sh) | (w_ld_hi << (XLEN - 32'(r_sh)));
`else
        w_ld_sh = mem_rdata >> r_sh;
`endif
        case (r_size)
            2'd0:    w_sign = w_ld_sh[7];
            2'd1:    w_sign = w_ld_sh[15];
            default: w_sign = w_ld_sh[31];
        endcase
        w_ld_ext = (w_ld_sh & w_rmask) | ((w_sign & ~r_unsigned) ? ~w_rmask : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = w_bad ? S_RESP : S_REQ0;
            S_REQ0:  if (mem_ready) w_next = S_WAIT0;
            S_WAIT0: if (mem_rvalid) begin
`ifdef YSYX_22050598_LSU_MISALIGN_EN
                w_next = (mem_err || !r_split) ? S_RESP : S_REQ1;
`else
                w_next = S_RESP;
`endif
            end
`ifdef YSYX_22050598_LSU_MISALIGN_EN
            S_REQ1:  if (mem_ready) w_next = S_WAIT1;
            S_WAIT1: if (mem_rvalid) w_next = S_RESP;
`endif
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_off       <= '0;
            r_size      <= '0;
            r_store     <= 1'b0;
            r_unsigned  <= 1'b0;
            r_err       <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_rsp_rdata <= '0;
`ifdef YSYX_22050598_LSU_MISALIGN_EN
            r_split     <= 1'b0;
            r_wdata_hi  <= '0;
            r_wstrb_hi  <= '0;
            r_rdata0    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_off       <= w_off;
                    r_size      <= req_size;
                    r_store     <= req_store;
                    r_unsigned  <= req_unsigned;
                    r_err       <= w_bad;
                    r_mem_valid <= ~w_bad;
                    r_mem_we    <= req_store & ~w_bad;
                    r_mem_addr  <= w_base;
                    r_mem_wdata <= req_store ? w_wdata_lo : '0;
                    r_mem_wstrb <= (req_store & ~w_bad) ? w_wstrb_lo : '0;
`ifdef YSYX_22050598_LSU_MISALIGN_EN
                    r_split     <= w_split;
                    r_wdata_hi  <= req_store ? w_wdata_hi : '0;
                    r_wstrb_hi  <= req_store ? w_wstrb_hi : '0;
`endif
                end
                S_REQ0: if (mem_ready) r_mem_valid <= 1'b0;
                S_WAIT0: if (mem_rvalid) begin
                    r_err <= mem_err;
`ifdef YSYX_22050598_LSU_MISALIGN_EN
                    r_rdata0 <= mem_rdata;
                    if (!mem_err && r_split) begin
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= r_mem_addr + ADDR_W'(NB);
                        r_mem_wdata <= r_wdata_hi;
                        r_mem_wstrb <= r_wstrb_hi;
                    end else begin
                        r_rsp_rdata <= (mem_err || r_store) ? '0 : w_ld_ext;
                    end
`else
                    r_rsp_rdata <= (mem_err || r_store) ? '0 : w_ld_ext;
`endif
                end
`ifdef YSYX_22050598_LSU_MISALIGN_EN
                S_REQ1: if (mem_ready) r_mem_valid <= 1'b0;
                S_WAIT1: if (mem_rvalid) begin
                    r_err       <= mem_err;
                    r_rsp_rdata <= (mem_err || r_store) ? '0 : w_ld_ext;
                end
`endif
                S_RESP: begin
                    r_err       <= 1'b0;
                    r_rsp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_err   = rsp_valid & r_err;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_ysyx_22050598_lsu_mc.sv
// tb_ysyx_22050598_lsu_mc: randomized and directed accesses against a byte-level memory model.
// Expectations follow YSYX_22050598_LSU_MISALIGN_EN when the bench is built with it.
module tb_ysyx_22050598_lsu_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        mem_err = 1'b0;

    int checks = 0;
    int failures = 0;

`ifdef YSYX_22050598_LSU_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    ysyx_22050598_lsu_mc #(.XLEN(64), .ADDR_W(64)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem_img [logic [63:0]];
    logic [7:0]  wr_bytes [logic [63:0]];
    logic [63:0] bq_addr [$];
    logic [63:0] bq_wdata [$];
    logic [7:0]  bq_strb [$];
    logic        bq_we [$];
    logic [63:0] g_rd;
    logic        g_err;
    int          g_lat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [63:0] a);
        logic [7:0] h;
        if (mem_img.exists(a)) return mem_img[a];
        h = a[7:0] * 8'd53;
        return h ^ a[15:8] ^ 8'hA5;
    endfunction

    task automatic put64(input logic [63:0] a, input logic [63:0] v);
        for (int i = 0; i < 8; i++) mem_img[a + 64'(i)] = v[8*i +: 8];
    endtask

    // One full access: drive the request, act as the bus, then compare with the model.
    task automatic run_op(input logic st, input logic [63:0] a, input logic [63:0] wd,
                          input logic [1:0] sz, input logic uns, input int stall,
                          input int errbeat, input string tag);
        bit in_beat = 0, resp_due = 0, got = 0;
        int nb = 0, stalls = 0, off, len, exp_nb, exp_lat;
        bit bad, split, exp_err;
        logic [63:0] s_addr = '0, s_wdata = '0, baddr = '0, val, m, exp_rd;
        logic [8:0]  s_ws = '0;
        logic [7:0]  wb;

        bq_addr.delete(); bq_wdata.delete(); bq_strb.delete(); bq_we.delete();
        wr_bytes.delete();
        req_valid = 1'b1; req_store = st; req_addr = a; req_wdata = wd;
        req_size = sz; req_unsigned = uns;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 80 && !got; c++) begin
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
            if (rsp_valid) begin
                got = 1; g_lat = c; g_rd = rsp_rdata; g_err = rsp_err;
            end else begin
                if (resp_due) begin
                    resp_due = 0;
                    mem_rvalid = 1'b1;
                    for (int k = 0; k < 8; k++) mem_rdata[8*k +: 8] = mem_rd(baddr + 64'(k));
                    mem_err = (errbeat == nb - 1);
                end else if (mem_valid) begin
                    if (!in_beat) begin
                        in_beat = 1; stalls = 0; nb++;
                        s_addr = mem_addr; s_wdata = mem_wdata; s_ws = {mem_we, mem_wstrb};
                        bq_addr.push_back(mem_addr); bq_wdata.push_back(mem_wdata);
                        bq_strb.push_back(mem_wstrb); bq_we.push_back(mem_we);
                    end else begin
                        chk({tag, "_stall_addr"}, mem_addr, s_addr);
                        chk({tag, "_stall_wdata"}, mem_wdata, s_wdata);
                        chk({tag, "_stall_we_strb"}, 64'({mem_we, mem_wstrb}), 64'(s_ws));
                    end
                    if (stalls < stall) stalls++;
                    else begin
                        mem_ready = 1'b1; resp_due = 1; in_beat = 0; baddr = mem_addr;
                        if (mem_we)
                            for (int k = 0; k < 8; k++)
                                if (mem_wstrb[k]) wr_bytes[mem_addr + 64'(k)] = mem_wdata[8*k +: 8];
                    end
                end
                @(negedge clk);
            end
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
        if (!got) chk({tag, "_rsp_timeout"}, 64'd0, 64'd1);

        off = int'(a[2:0]);
        len = 1 << sz;
        bad = !MIS && ((off % len) != 0);
        split = !bad && (off + len > 8);
        exp_nb = bad ? 0 : ((split && errbeat != 0) ? 2 : 1);
        exp_err = bad || (errbeat == 0) || (errbeat == 1 && split);
        exp_lat = bad ? 1 : 3 + ((exp_nb == 2) ? 2 : 0) + stall * exp_nb;
        val = '0;
        for (int i = 0; i < len; i++) val |= 64'(mem_rd(a + 64'(i))) << (8 * i);
        m = (len == 8) ? '1 : ((64'd1 << (8 * len)) - 64'd1);
        if (!uns && len < 8 && val[8*len-1]) val |= ~m;
        exp_rd = (exp_err || st) ? 64'd0 : val;

        if (got) begin
            chk({tag, "_latency"}, 64'(g_lat), 64'(exp_lat));
            chk({tag, "_rsp_err"}, 64'(g_err), 64'(exp_err));
            chk({tag, "_rsp_rdata"}, g_rd, exp_rd);
        end
        chk({tag, "_beats"}, 64'(nb), 64'(exp_nb));
        for (int i = 0; i < nb && i < exp_nb; i++) begin
            chk({tag, "_beat_addr"}, bq_addr[i], (a & ~64'd7) + 64'(8 * i));
            chk({tag, "_beat_we"}, 64'(bq_we[i]), 64'(st));
            if (!st) chk({tag, "_rd_wstrb"}, 64'(bq_strb[i]), 64'd0);
        end
        if (st && !exp_err) begin
            chk({tag, "_wr_count"}, 64'(wr_bytes.num()), 64'(len));
            for (int i = 0; i < len; i++) begin
                wb = 'x;
                if (wr_bytes.exists(a + 64'(i))) wb = wr_bytes[a + 64'(i)];
                chk({tag, "_wr_byte"}, 64'(wb), 64'(wd[8*i +: 8]));
            end
        end
        @(negedge clk);
        chk({tag, "_ready_after"}, 64'(req_ready), 64'd1);
        chk({tag, "_rsp_after"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        int r;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_mem_valid", 64'(mem_valid), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_mem_addr", mem_addr, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        put64(64'h8000_0000, 64'h1122_3344_8899_AABB);
        run_op(1'b0, 64'h8000_0003, 64'd0, 2'd0, 1'b0, 0, -1, "lb");
        chk("lb_value", g_rd, 64'hFFFF_FFFF_FFFF_FF88);
        chk("lb_addr", bq_addr[0], 64'h8000_0000);
        chk("lb_latency", 64'(g_lat), 64'd3);
        run_op(1'b0, 64'h8000_0003, 64'd0, 2'd0, 1'b1, 0, -1, "lbu");
        chk("lbu_value", g_rd, 64'h88);

        run_op(1'b1, 64'h8000_0006, 64'h1234_5678_9ABC_BEEF, 2'd1, 1'b0, 0, -1, "sh");
        chk("sh_wstrb", 64'(bq_strb[0]), 64'hC0);
        chk("sh_wdata_hi", 64'(bq_wdata[0][63:48]), 64'hBEEF);
        chk("sh_we", 64'(bq_we[0]), 64'd1);

        put64(64'h8000_0000, 64'hDDCC_0000_0000_0000);
        put64(64'h8000_0008, 64'h0000_0000_0000_BBAA);
        run_op(1'b0, 64'h8000_0006, 64'd0, 2'd2, 1'b0, 0, -1, "lw_split");
        chk("lw_split_value", g_rd, MIS ? 64'hFFFF_FFFF_BBAA_DDCC : 64'd0);

        run_op(1'b1, 64'h8000_0004, 64'hCAFE_F00D_1357_2468, 2'd3, 1'b0, 0, -1, "sd_mis");
        chk("sd_mis_err", 64'(g_err), MIS ? 64'd0 : 64'd1);

        run_op(1'b0, 64'h8000_0046, 64'd0, 2'd2, 1'b0, 3, 0, "err_stall");
        chk("err_stall_rdata", g_rd, 64'd0);
        chk("err_stall_err", 64'(g_err), 64'd1);
        run_op(1'b0, 64'h8000_0040, 64'd0, 2'd3, 1'b0, 2, 0, "err_aligned");
        run_op(1'b1, 64'h8000_00FC, 64'h0102_0304_0506_0708, 2'd3, 1'b0, 1, 1, "err_beat1");

        req_valid = 1'b1; req_store = 1'b0; req_addr = 64'h8000_0010;
        req_size = 2'd3; req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_pre_valid", 64'(mem_valid), 64'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("rst_pre_addr", mem_addr, 64'h8000_0010);
        chk("rst_pre_ready", 64'(req_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_ready", 64'(req_ready), 64'd1);
        chk("rst_async_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_async_mem_addr", mem_addr, 64'd0);
        chk("rst_async_we_strb", 64'({mem_we, mem_wstrb}), 64'd0);
        chk("rst_async_wdata", mem_wdata, 64'd0);
        chk("rst_async_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
        chk("rst_async_rdata", rsp_rdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom};
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("late_rvalid_rsp", 64'(rsp_valid), 64'd0);
        chk("late_rvalid_ready", 64'(req_ready), 64'd1);
        chk("late_rvalid_mem_valid", 64'(mem_valid), 64'd0);

        run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 2'd2, 1'b0, 0, -1, "wrap");
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hA5A5_5A5A_0F0F_F0F0, 2'd3, 1'b0, 0, -1, "wrap_sd");

        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            a = (r == 9) ? (64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7)))
                         : (64'h8000_0000 + 64'($urandom_range(0, 255)));
            r = int'($urandom_range(0, 9));
            run_op(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), (r < 2) ? r : -1, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
